ahb_grant_ctrl: RTL and testbench
=================================

// Module: ahb_grant_ctrl
// PURPOSE
// Sequential grant controller downstream of the combinational fixed-priority arbiter_split. Holds the arbiter's
// combinational hgrant/hmaster proposal until a legal handover point: hready high, burst complete, no lock held.
// Drives the registered address-phase and data-phase master IDs and hmastlock.
// Owns the SPLIT mask register (hsplit_reg) and the release vector (split_rel) that arbiter_split consumes.
// PARAMETERS
// NUM_MASTERS    2    number of bus masters; hmaster is one-hot of this width (bit i = hbusreq[i])
// SPLIT_TIMEOUT  256  cycles before auto-release of a masked master (only with SPLIT_TIMEOUT_EN)
// PORTS
// hclk           in   1    bus clock, all state on rising edge
// hresetn        in   1    asynchronous, active-low reset
// hgrant_nxt     in   2    arbiter_split proposed grant (one-hot, DEFAULT_MASTER when none)
// hmaster_nxt    in   2    arbiter_split proposed master ID
// hlock          in   2    per-master lock request
// htrans         in   2    current address-phase transfer type
// hburst         in   3    current address-phase burst type
// hready         in   1    transfer-done from slave mux
// hresp          in   2    slave response (OKAY/ERROR/RETRY/SPLIT)
// hsplit         in   16   slave SPLIT-release vector, bit i = master one-hot bit i
// hgrant         out  2    registered grant
// hmaster        out  2    address-phase owner
// hmaster_d      out  2    data-phase owner
// hmastlock      out  1    current address phase is locked
// hsplit_reg     out  16   masters masked by SPLIT, to arbiter_split
// split_rel      out  16   hsplit & hsplit_reg, combinational, to arbiter_split 'split'
// split_timeout  out  1    one-cycle pulse on forced release (0 without SPLIT_TIMEOUT_EN)
// BEHAVIOUR
// - Reset values: hgrant = hmaster = DEFAULT_MASTER; hmaster_d = 0; hmastlock = 0; hsplit_reg = 0; state = IDLE; beat count = 0.
// - Reset is effective immediately, mid-burst or mid-SPLIT included; no transfer state survives it.
// - On every hready=1 edge: hmaster_d <= hmaster. Handover loads hgrant <= hgrant_nxt and hmaster <= hmaster_nxt.
// - FSM states: IDLE, BURST, LOCKED, RESP1, RESP2.
//   IDLE: handover on every hready=1 cycle.
//     -> BURST on NONSEQ & hready when beats > 1.
//     -> LOCKED when hlock & hgrant_nxt != 0 at handover.
//   BURST: no handover. SEQ & hready decrements the beat count.
//     -> IDLE (with handover) when the count reaches 0 and hready=1.
//   BURST, INCR (undefined length): grant held while htrans is SEQ or BUSY; exit on IDLE or NONSEQ.
//   LOCKED: no handover; hmastlock = 1.
//     -> IDLE when hlock & hmaster == 0 at hready=1 with htrans IDLE or NONSEQ.
//   Any state, hresp in {SPLIT, RETRY} & !hready -> RESP1 (first response cycle).
//     On SPLIT: hsplit_reg |= {14'b0, hmaster_d}.
//   RESP1, hready=1 -> RESP2. Forced handover from the arbiter's now-masked proposal; beat count cleared.
//   RESP2 -> IDLE the next cycle.
//   ERROR, or OKAY with hready=0: no FSM effect.
// - Beat count loads beats-1 on NONSEQ: SINGLE=0, INCR4/WRAP4=3, INCR8/WRAP8=7, INCR16/WRAP16=15.
// - Split mask update: hsplit_reg <= (hsplit_reg & ~hsplit) | set_mask.
//   Set and release of the same bit in one cycle: set wins.
//   hsplit bits for unmasked masters are ignored.
//   Bits [15:NUM_MASTERS] are always 0.
// CONFIGURATION
// SPLIT_TIMEOUT_EN defined: one counter per master, running while its hsplit_reg bit is set.
//   Reaching SPLIT_TIMEOUT clears the bit and pulses split_timeout for 1 cycle.
//   The counter clears when the bit clears.
// SPLIT_TIMEOUT_EN undefined: no counters; masked masters wait only on hsplit; split_timeout tied 0.
// STRUCTURE
// ahb_pkg: HTRANS_*/HRESP_*/HBURST_* encodings, DEFAULT_MASTER, typedef enum grant_state_t.
// Sub-module ahb_beat_counter: load from hburst, decrement on SEQ&hready, last-beat flag, INCR flag.
// TESTING
// 1. Reset: hresetn=0 -> hgrant=DEFAULT_MASTER, hsplit_reg=0, hmastlock=0. Release -> first handover follows hgrant_nxt=2'b01 on hready.
// 2. Master 0 INCR4, hgrant_nxt switches to 2'b10 at beat 2 -> hgrant holds 2'b01 until beat 4 completes, then 2'b10.
// 3. Master 1 SPLIT: hresp=SPLIT, hready=0 -> hsplit_reg=16'h0002. Next hready=1 -> handover to arbiter proposal.
//    Later hsplit=16'h0002 -> split_rel=16'h0002 that cycle; hsplit_reg=0 next cycle.
// 4. hlock=2'b01 during handover -> hmastlock=1 and grant frozen across hgrant_nxt changes until hlock drops at an IDLE/NONSEQ boundary.
// 5. hresetn low mid-INCR8 beat 5 with hsplit_reg=2 -> all outputs return to reset values immediately.
// 6. With SPLIT_TIMEOUT_EN and SPLIT_TIMEOUT=8: mask set, no hsplit for 8 cycles -> bit clears and split_timeout pulses once.
//    Same-cycle set and release of one bit -> bit stays set.

Source files
------------

// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
// Shared AHB encodings for the grant controller: HTRANS / HRESP / HBURST
// codes, the default bus master index, the grant FSM state type and a helper
// that maps a burst type to its beat count minus one.
// No ports (package).
// ---------------------------------------------------------------------------
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;
  localparam logic [1:0] HRESP_RETRY   = 2'b10;
  localparam logic [1:0] HRESP_SPLIT   = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  // Index of the master that owns the bus when nobody requests it.
  localparam int DEFAULT_MASTER = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BURST  = 3'd1,
    ST_LOCKED = 3'd2,
    ST_RESP1  = 3'd3,
    ST_RESP2  = 3'd4
  } grant_state_t;

  // Remaining beats after the NONSEQ beat. INCR has no defined length and
  // is tracked separately by the INCR flag, so it maps to 0 like SINGLE.
  function automatic logic [3:0] burst_beats_m1(input logic [2:0] hburst);
    case (hburst)
      HBURST_WRAP4,  HBURST_INCR4:  burst_beats_m1 = 4'd3;
      HBURST_WRAP8,  HBURST_INCR8:  burst_beats_m1 = 4'd7;
      HBURST_WRAP16, HBURST_INCR16: burst_beats_m1 = 4'd15;
      default:                      burst_beats_m1 = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_beat_counter.sv
// ---------------------------------------------------------------------------
// ahb_beat_counter
// Tracks the remaining beats of the current burst.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load         : NONSEQ accepted (htrans=NONSEQ & hready), load from i_hburst
//   i_dec          : SEQ accepted (htrans=SEQ & hready), count down
//   i_clr          : forced clear (SPLIT/RETRY handover), wins over load
//   i_hburst       : burst type of the current address phase
//   o_last         : one beat left, the next accepted SEQ ends the burst
//   o_multi        : i_hburst describes a burst of more than one beat
//   o_incr         : the burst in progress is undefined-length INCR
// ---------------------------------------------------------------------------
module ahb_beat_counter
  import ahb_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic       i_dec,
  input  logic       i_clr,
  input  logic [2:0] i_hburst,
  output logic       o_last,
  output logic       o_multi,
  output logic       o_incr
);

  logic [3:0] r_count;
  logic       r_incr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
      r_incr  <= 1'b0;
    end else if (i_clr) begin
      r_count <= '0;
      r_incr  <= 1'b0;
    end else if (i_load) begin
      r_count <= burst_beats_m1(i_hburst);
      r_incr  <= (i_hburst == HBURST_INCR);
    end else if (i_dec && (r_count != 4'd0)) begin
      r_count <= r_count - 4'd1;
    end
  end

  assign o_last  = (r_count == 4'd1);
  assign o_multi = (i_hburst != HBURST_SINGLE);
  assign o_incr  = r_incr;

endmodule

// File: rtl/ahb_grant_ctrl.sv
// ---------------------------------------------------------------------------
// ahb_grant_ctrl
// Sequential grant controller behind the combinational arbiter. Holds the
// arbiter's proposed grant until a legal handover point (hready high, burst
// finished, no lock held), registers the address- and data-phase owners and
// hmastlock, and owns the SPLIT mask plus the release vector fed back to the
// arbiter.
// Optional feature macro: SPLIT_TIMEOUT_EN (per-master auto-release of a
// SPLIT-masked master after SPLIT_TIMEOUT cycles).
// Ports:
//   i_hclk, i_hresetn  : bus clock, asynchronous active-low reset
//   i_hgrant_nxt       : arbiter proposed grant (one-hot)
//   i_hmaster_nxt      : arbiter proposed master (one-hot)
//   i_hlock            : per-master lock request
//   i_htrans, i_hburst : current address-phase transfer / burst type
//   i_hready, i_hresp  : slave transfer-done and response
//   i_hsplit           : slave SPLIT-release vector
//   o_hgrant           : registered grant
//   o_hmaster          : address-phase owner
//   o_hmaster_d        : data-phase owner
//   o_hmastlock        : current address phase is locked
//   o_hsplit_reg       : masters masked by SPLIT
//   o_split_rel        : i_hsplit & o_hsplit_reg (combinational)
//   o_split_timeout    : one-cycle pulse on forced release
// ---------------------------------------------------------------------------
module ahb_grant_ctrl
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS   = 2,
  parameter int SPLIT_TIMEOUT = 256
) (
  input  logic                   i_hclk,
  input  logic                   i_hresetn,
  input  logic [NUM_MASTERS-1:0] i_hgrant_nxt,
  input  logic [NUM_MASTERS-1:0] i_hmaster_nxt,
  input  logic [NUM_MASTERS-1:0] i_hlock,
  input  logic [1:0]             i_htrans,
  input  logic [2:0]             i_hburst,
  input  logic                   i_hready,
  input  logic [1:0]             i_hresp,
  input  logic [15:0]            i_hsplit,
  output logic [NUM_MASTERS-1:0] o_hgrant,
  output logic [NUM_MASTERS-1:0] o_hmaster,
  output logic [NUM_MASTERS-1:0] o_hmaster_d,
  output logic                   o_hmastlock,
  output logic [15:0]            o_hsplit_reg,
  output logic [15:0]            o_split_rel,
  output logic                   o_split_timeout
);

  localparam logic [NUM_MASTERS-1:0] DEF_GRANT =
    {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;

  grant_state_t           r_state, w_state_nxt;
  logic [NUM_MASTERS-1:0] r_hgrant, r_hmaster, r_hmaster_d, r_hsplit_reg;
  logic                   w_handover, w_cnt_clr;
  logic                   w_last, w_multi, w_incr;
  logic                   w_nonseq, w_seq, w_idle_t, w_resp_hold;
  logic [NUM_MASTERS-1:0] w_set, w_rel, w_to_clr;

  assign w_nonseq    = (i_htrans == HTRANS_NONSEQ);
  assign w_seq       = (i_htrans == HTRANS_SEQ);
  assign w_idle_t    = (i_htrans == HTRANS_IDLE);
  assign w_resp_hold = ((i_hresp == HRESP_SPLIT) || (i_hresp == HRESP_RETRY)) && !i_hready;

  // The data-phase owner is the master that just got SPLIT.
  assign w_set = ((i_hresp == HRESP_SPLIT) && !i_hready) ? r_hmaster_d : '0;
  assign w_rel = o_split_rel[NUM_MASTERS-1:0];

  ahb_beat_counter u_beat_counter (
    .i_clk    (i_hclk),
    .i_rst_n  (i_hresetn),
    .i_load   (w_nonseq && i_hready),
    .i_dec    (w_seq && i_hready),
    .i_clr    (w_cnt_clr),
    .i_hburst (i_hburst),
    .o_last   (w_last),
    .o_multi  (w_multi),
    .o_incr   (w_incr)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_handover  = 1'b0;
    w_cnt_clr   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_hready) begin
          w_handover = 1'b1;
          if ((i_hlock & i_hgrant_nxt) != '0) w_state_nxt = ST_LOCKED;
          else if (w_nonseq && w_multi)       w_state_nxt = ST_BURST;
        end
      end
      ST_BURST: begin
        if (i_hready) begin
          // INCR has no length: it ends when the master stops issuing SEQ/BUSY.
          if (w_incr ? (w_idle_t || w_nonseq) : (w_seq && w_last)) begin
            w_handover  = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_LOCKED: begin
        if (i_hready && ((i_hlock & r_hmaster) == '0) && (w_idle_t || w_nonseq)) begin
          w_handover  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RESP1: begin
        // Second response cycle: the arbiter already sees the new mask.
        if (i_hready) begin
          w_handover  = 1'b1;
          w_cnt_clr   = 1'b1;
          w_state_nxt = ST_RESP2;
        end
      end
      ST_RESP2: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (w_resp_hold) w_state_nxt = ST_RESP1;
  end

  always_ff @(posedge i_hclk or negedge i_hresetn) begin
    if (!i_hresetn) begin
      r_state      <= ST_IDLE;
      r_hgrant     <= DEF_GRANT;
      r_hmaster    <= DEF_GRANT;
      r_hmaster_d  <= '0;
      r_hsplit_reg <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_handover) begin
        r_hgrant  <= i_hgrant_nxt;
        r_hmaster <= i_hmaster_nxt;
      end
      if (i_hready) r_hmaster_d <= r_hmaster;
      // A new SPLIT beats a same-cycle release or timeout of that master.
      r_hsplit_reg <= (r_hsplit_reg & ~w_rel & ~w_to_clr) | w_set;
    end
  end

`ifdef SPLIT_TIMEOUT_EN
  localparam int TO_W = $clog2(SPLIT_TIMEOUT + 1);

  logic [TO_W-1:0]        r_to_cnt [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] w_to_fire;

  always_comb begin
    w_to_fire = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      w_to_fire[i] = r_hsplit_reg[i] && (r_to_cnt[i] == TO_W'(SPLIT_TIMEOUT - 1));
  end

  always_ff @(posedge i_hclk or negedge i_hresetn) begin
    if (!i_hresetn) begin
      for (int i = 0; i < NUM_MASTERS; i++) r_to_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (!r_hsplit_reg[i] || w_to_fire[i]) r_to_cnt[i] <= '0;
        else                                  r_to_cnt[i] <= r_to_cnt[i] + 1'b1;
      end
    end
  end

  assign w_to_clr        = w_to_fire & ~w_set;
  assign o_split_timeout = |w_to_clr;
`else
  assign w_to_clr        = '0;
  assign o_split_timeout = 1'b0;
`endif

  assign o_hgrant     = r_hgrant;
  assign o_hmaster    = r_hmaster;
  assign o_hmaster_d  = r_hmaster_d;
  assign o_hmastlock  = (r_state == ST_LOCKED);
  assign o_hsplit_reg = 16'(r_hsplit_reg);
  assign o_split_rel  = i_hsplit & o_hsplit_reg;

endmodule

// File: tb/tb_ahb_grant_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ahb_grant_ctrl
// Directed bench for ahb_grant_ctrl: reset, handover, INCR4 hold, SPLIT mask
// set/release, set-wins, lock hold, asynchronous reset mid-INCR8 and, when
// SPLIT_TIMEOUT_EN is defined, the SPLIT timeout release.
// ---------------------------------------------------------------------------
module tb_ahb_grant_ctrl;
  import ahb_pkg::*;

  logic        clk = 1'b0;
  logic        hresetn;
  logic [1:0]  hgrant_nxt, hmaster_nxt, hlock, htrans, hresp;
  logic [2:0]  hburst;
  logic        hready;
  logic [15:0] hsplit;
  logic [1:0]  hgrant, hmaster, hmaster_d;
  logic        hmastlock, split_timeout;
  logic [15:0] hsplit_reg, split_rel;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  ahb_grant_ctrl #(.NUM_MASTERS(2), .SPLIT_TIMEOUT(8)) dut (
    .i_hclk          (clk),
    .i_hresetn       (hresetn),
    .i_hgrant_nxt    (hgrant_nxt),
    .i_hmaster_nxt   (hmaster_nxt),
    .i_hlock         (hlock),
    .i_htrans        (htrans),
    .i_hburst        (hburst),
    .i_hready        (hready),
    .i_hresp         (hresp),
    .i_hsplit        (hsplit),
    .o_hgrant        (hgrant),
    .o_hmaster       (hmaster),
    .o_hmaster_d     (hmaster_d),
    .o_hmastlock     (hmastlock),
    .o_hsplit_reg    (hsplit_reg),
    .o_split_rel     (split_rel),
    .o_split_timeout (split_timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    hresetn = 1'b0; hgrant_nxt = 2'b10; hmaster_nxt = 2'b10; hlock = 2'b00;
    htrans = HTRANS_IDLE; hburst = HBURST_SINGLE; hready = 1'b0;
    hresp = HRESP_OKAY; hsplit = 16'h0;
    repeat (2) tick();

    // 1. reset values, then first handover
    chk("rst_hgrant",    16'(hgrant),        16'h0002);
    chk("rst_hmaster",   16'(hmaster),       16'h0002);
    chk("rst_hmaster_d", 16'(hmaster_d),     16'h0000);
    chk("rst_hmastlock", 16'(hmastlock),     16'h0000);
    chk("rst_hsplit",    hsplit_reg,         16'h0000);
    chk("rst_timeout",   16'(split_timeout), 16'h0000);
    hresetn = 1'b1; hgrant_nxt = 2'b01; hmaster_nxt = 2'b01;
    tick();
    chk("hold_no_hready", 16'(hgrant), 16'h0002);
    hready = 1'b1;
    tick();
    chk("ho1_hgrant",    16'(hgrant),    16'h0001);
    chk("ho1_hmaster",   16'(hmaster),   16'h0001);
    chk("ho1_hmaster_d", 16'(hmaster_d), 16'h0002);

    // 2. master 0 INCR4, proposal changes at beat 2
    htrans = HTRANS_NONSEQ; hburst = HBURST_INCR4;
    tick();
    chk("incr4_b1", 16'(hgrant), 16'h0001);
    htrans = HTRANS_SEQ; hgrant_nxt = 2'b10; hmaster_nxt = 2'b10;
    tick();
    chk("incr4_b2", 16'(hgrant), 16'h0001);
    hready = 1'b0;
    tick();
    chk("incr4_wait", 16'(hgrant), 16'h0001);
    hready = 1'b1;
    tick();
    chk("incr4_b3", 16'(hgrant), 16'h0001);
    tick();
    chk("incr4_end_hgrant",  16'(hgrant),  16'h0002);
    chk("incr4_end_hmaster", 16'(hmaster), 16'h0002);

    // 3. master 1 SPLIT, then release
    htrans = HTRANS_IDLE;
    tick();
    chk("split_dphase", 16'(hmaster_d), 16'h0002);
    hresp = HRESP_SPLIT; hready = 1'b0;
    tick();
    chk("split_set", hsplit_reg, 16'h0002);
    hgrant_nxt = 2'b01; hmaster_nxt = 2'b01; hready = 1'b1;
    tick();
    chk("split_ho_hgrant", 16'(hgrant), 16'h0001);
    chk("split_ho_mask",   hsplit_reg,  16'h0002);
    hresp = HRESP_OKAY;
    tick();
    hsplit = 16'h0003;
    #1;
    chk("split_rel", split_rel, 16'h0002);
    tick();
    chk("split_cleared", hsplit_reg, 16'h0000);
    hsplit = 16'h0;

    // same-cycle set and release of master 0: set wins
    hresp = HRESP_SPLIT; hready = 1'b0;
    tick();
    chk("m0_split_set", hsplit_reg, 16'h0001);
    hsplit = 16'h0001;
    #1;
    chk("m0_split_rel", split_rel, 16'h0001);
    tick();
    chk("set_wins", hsplit_reg, 16'h0001);
    hsplit = 16'h0; hgrant_nxt = 2'b10; hmaster_nxt = 2'b10; hready = 1'b1;
    tick();
    chk("m0_split_ho", 16'(hgrant), 16'h0002);
    hresp = HRESP_OKAY;
    tick();
    hsplit = 16'h0001;
    tick();
    chk("m0_released", hsplit_reg, 16'h0000);
    chk("no_timeout",  16'(split_timeout), 16'h0000);
    hsplit = 16'h0;

    // 4. locked transfer
    hgrant_nxt = 2'b01; hmaster_nxt = 2'b01; hlock = 2'b01;
    tick();
    chk("lock_on",     16'(hmastlock), 16'h0001);
    chk("lock_hgrant", 16'(hgrant),    16'h0001);
    hgrant_nxt = 2'b10; hmaster_nxt = 2'b10; htrans = HTRANS_NONSEQ; hburst = HBURST_SINGLE;
    tick();
    chk("lock_hold1", 16'(hgrant),    16'h0001);
    chk("lock_mlk1",  16'(hmastlock), 16'h0001);
    hlock = 2'b00; htrans = HTRANS_SEQ;
    tick();
    chk("lock_hold_seq", 16'(hgrant),    16'h0001);
    chk("lock_mlk_seq",  16'(hmastlock), 16'h0001);
    htrans = HTRANS_IDLE;
    tick();
    chk("unlock_hgrant", 16'(hgrant),    16'h0002);
    chk("unlock_mlk",    16'(hmastlock), 16'h0000);

    // 5. reset mid-INCR8 with master 1 masked
    tick();
    hresp = HRESP_SPLIT; hready = 1'b0;
    tick();
    chk("pre_rst_mask", hsplit_reg, 16'h0002);
    hgrant_nxt = 2'b01; hmaster_nxt = 2'b01; hready = 1'b1;
    tick();
    hresp = HRESP_OKAY;
    tick();
    htrans = HTRANS_NONSEQ; hburst = HBURST_INCR8;
    tick();
    htrans = HTRANS_SEQ; hgrant_nxt = 2'b10; hmaster_nxt = 2'b10;
    repeat (3) tick();
    chk("incr8_b4_hold", 16'(hgrant), 16'h0001);
    hresetn = 1'b0;
    #2;
    chk("arst_hgrant",    16'(hgrant),    16'h0002);
    chk("arst_hmaster",   16'(hmaster),   16'h0002);
    chk("arst_hmaster_d", 16'(hmaster_d), 16'h0000);
    chk("arst_hsplit",    hsplit_reg,     16'h0000);
    chk("arst_hmastlock", 16'(hmastlock), 16'h0000);
    hresetn = 1'b1; hgrant_nxt = 2'b01; hmaster_nxt = 2'b01;
    tick();
    chk("post_rst_ho", 16'(hgrant), 16'h0001);
    htrans = HTRANS_IDLE;

`ifdef SPLIT_TIMEOUT_EN
    // 6. timeout release of master 0 after 8 cycles
    tick();
    hresp = HRESP_SPLIT; hready = 1'b0;
    tick();
    chk("to_set", hsplit_reg, 16'h0001);
    hready = 1'b1;
    tick();
    hresp = HRESP_OKAY;
    repeat (5) tick();
    chk("to_not_yet", 16'(split_timeout), 16'h0000);
    tick();
    chk("to_pulse",    16'(split_timeout), 16'h0001);
    chk("to_mask_set", hsplit_reg,         16'h0001);
    tick();
    chk("to_cleared",  hsplit_reg,         16'h0000);
    chk("to_pulse_end", 16'(split_timeout), 16'h0000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
